// File: rtl/multicycle_ctrl_v2.sv
// Multicycle MIPS control FSM with a MemReq/MemReady handshake,
// a configurable memory-wait timeout and an illegal-instruction trap.
// Datapath controls are decoded combinationally from the current state,
// Opcode, Func and MemReady. The Illegal/MemFault flags are registered.
// Zero is accepted for interface completeness only; the datapath itself
// forms PCWrite | (PCWriteCond & (Zero ^ BranchNE)).
module multicycle_ctrl_v2 #(
    parameter int ALU_CTRL_W   = 4,
    parameter int MEM_TIMEOUT  = 15,
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            Opcode,
    input  logic [5:0]            Func,
    input  logic                  Zero,
    input  logic                  MemReady,
    output logic                  MemReq,
    output logic                  Fetch,
    output logic                  IRWrite,
    output logic                  IorD,
    output logic                  MemWrite,
    output logic                  MemToReg,
    output logic                  RegDst,
    output logic                  ALUSrc,
    output logic                  Shift,
    output logic                  RegWrite,
    output logic                  PCWrite,
    output logic                  PCWriteCond,
    output logic                  BranchNE,
    output logic [1:0]            PCSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  InstrDone,
    output logic                  Illegal,
    output logic                  MemFault
);

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_REXE, S_RWB, S_IEXE, S_IWB,
        S_ADDR, S_MRD, S_MWB, S_MWR, S_BR, S_JMP, S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;

    // Counter only needs to reach MEM_TIMEOUT-1; a timeout of 0 never compares.
    localparam int             CNT_W   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic             dec_legal;
    state_t           dec_state;

    // True for the R-type functions this controller implements.
    function automatic logic r_legal(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b000000, 6'b000010: r_legal = 1'b1;
            default:                          r_legal = 1'b0;
        endcase
    endfunction

    // ALU operation for an R-type function field.
    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'b100000: r_alu = 3'd0;
            6'b100010: r_alu = 3'd1;
            6'b100100: r_alu = 3'd2;
            6'b100101: r_alu = 3'd3;
            6'b100110: r_alu = 3'd4;
            6'b000000: r_alu = 3'd5;
            6'b000010: r_alu = 3'd6;
            default:   r_alu = 3'd0;
        endcase
    endfunction

    // ALU operation for an immediate ALU opcode.
    function automatic logic [2:0] i_alu(input logic [5:0] op);
        case (op)
            OP_ADDI: i_alu = 3'd0;
            OP_ANDI: i_alu = 3'd2;
            OP_ORI:  i_alu = 3'd3;
            OP_XORI: i_alu = 3'd4;
            OP_LUI:  i_alu = 3'd7;
            default: i_alu = 3'd0;
        endcase
    endfunction

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST) && !MemReady;

    // Instruction class decode used when leaving DECODE.
    always_comb begin
        dec_legal = 1'b1;
        dec_state = S_FETCH;
        case (Opcode)
            OP_RTYPE: begin
                dec_legal = r_legal(Func);
                dec_state = S_REXE;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: dec_state = S_IEXE;
            OP_LW, OP_SW:                              dec_state = S_ADDR;
            OP_BEQ, OP_BNE:                            dec_state = S_BR;
            OP_J:                                      dec_state = S_JMP;
            default:                                   dec_legal = 1'b0;
        endcase
    end

    // State sequencing, memory-wait counter and sticky fault flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_RST;
            wait_cnt <= {CNT_W{1'b0}};
            Illegal  <= 1'b0;
            MemFault <= 1'b0;
        end else begin
            // Entry into any wait state follows a MemReady=1 or a non-wait
            // state, so the counter is always zero on entry.
            if ((state == S_FETCH || state == S_MRD || state == S_MWR) && !MemReady) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= {CNT_W{1'b0}};
            end

            case (state)
                S_RST:   state <= S_FETCH;
                S_FETCH: begin
                    if (MemReady) begin
                        state <= S_DECODE;
                    end else if (timeout_hit) begin
                        state    <= S_TRAP;
                        MemFault <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        state <= dec_state;
                    end else if (TRAP_ILLEGAL) begin
                        state   <= S_TRAP;
                        Illegal <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_REXE:  state <= S_RWB;
                S_IEXE:  state <= S_IWB;
                S_ADDR: begin
                    if (Opcode == OP_LW) begin
                        state <= S_MRD;
                    end else if (Opcode == OP_SW) begin
                        state <= S_MWR;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_MRD: begin
                    if (MemReady) begin
                        state <= S_MWB;
                    end else if (timeout_hit) begin
                        state    <= S_TRAP;
                        MemFault <= 1'b1;
                    end else begin
                        state <= S_MRD;
                    end
                end
                S_MWR: begin
                    if (MemReady) begin
                        state <= S_FETCH;
                    end else if (timeout_hit) begin
                        state    <= S_TRAP;
                        MemFault <= 1'b1;
                    end else begin
                        state <= S_MWR;
                    end
                end
                S_RWB, S_IWB, S_MWB, S_BR, S_JMP: state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_RST;
            endcase
        end
    end

    // Datapath control decode; anything not driven for a state stays 0.
    always_comb begin
        MemReq      = 1'b0;
        Fetch       = 1'b0;
        IRWrite     = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        ALUSrc      = 1'b0;
        Shift       = 1'b0;
        RegWrite    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        PCSrc       = 2'd0;
        ALUControl  = {ALU_CTRL_W{1'b0}};
        InstrDone   = 1'b0;
        case (state)
            S_FETCH: begin
                Fetch   = 1'b1;
                MemReq  = 1'b1;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_REXE: begin
                ALUControl = ALU_CTRL_W'(r_alu(Func));
                Shift      = (Func == FN_SLL) || (Func == FN_SRL);
            end
            S_RWB: begin
                ALUControl = ALU_CTRL_W'(r_alu(Func));
                Shift      = (Func == FN_SLL) || (Func == FN_SRL);
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                InstrDone  = 1'b1;
            end
            S_IEXE: begin
                ALUSrc     = 1'b1;
                ALUControl = ALU_CTRL_W'(i_alu(Opcode));
            end
            S_IWB: begin
                ALUSrc     = 1'b1;
                ALUControl = ALU_CTRL_W'(i_alu(Opcode));
                RegWrite   = 1'b1;
                InstrDone  = 1'b1;
            end
            S_ADDR:  ALUSrc = 1'b1;
            S_MRD: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
            end
            S_MWB: begin
                MemToReg  = 1'b1;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MWR: begin
                MemReq    = 1'b1;
                IorD      = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = MemReady;
            end
            S_BR: begin
                ALUControl  = ALU_CTRL_W'(3'd1);
                PCWriteCond = 1'b1;
                PCSrc       = 2'd1;
                BranchNE    = (Opcode == OP_BNE);
                InstrDone   = 1'b1;
            end
            S_JMP: begin
                PCWrite   = 1'b1;
                PCSrc     = 2'd2;
                InstrDone = 1'b1;
            end
            default: begin
                MemReq = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/multicycle_ctrl_v2.md
Name: multicycle_ctrl_v2

Overview:
Parametrised successor to the multicycle MIPS control FSM. It sequences fetch, decode, execute, memory and write-back for R-type, I-type ALU, LW/SW, BEQ/BNE and J instructions. Memory access uses a MemReq/MemReady handshake with a configurable timeout instead of fixed-latency memory. The block sits between the IR opcode/func fields and the datapath mux/write-enable controls.

Parameters:
ALU_CTRL_W, 4, width of ALUControl (minimum 3)
MEM_TIMEOUT, 15, cycles to wait for MemReady before faulting; 0 disables the timeout
TRAP_ILLEGAL, 1, 1 = an unknown opcode/func halts in TRAP; 0 = it is treated as NOP and returns to FETCH

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
Opcode  in  6  IR[31:26], stable after IRWrite
Func  in  6  IR[5:0]
Zero  in  1  ALU zero flag
MemReady  in  1  memory completes the current MemReq this cycle
MemReq  out  1  memory access request
Fetch, IRWrite, IorD, MemWrite, MemToReg, RegDst, ALUSrc, Shift, RegWrite, PCWrite  out  1 each  datapath controls
PCWriteCond  out  1  conditional PC write on a branch
BranchNE  out  1  invert the Zero condition (BNE)
PCSrc  out  2  0 = ALU result, 1 = branch target register, 2 = jump target
ALUControl  out  ALU_CTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 lui
InstrDone  out  1  one-cycle pulse in the final state of each instruction
Illegal  out  1  sticky; the FSM is in TRAP because of decode
MemFault  out  1  sticky; the FSM is in TRAP because of timeout

Behaviour:
- Reset is asynchronous. It forces state=RST, timeout counter=0, Illegal=0, MemFault=0.
- In RST all outputs are 0. RST always moves to FETCH on the next edge.
- Outputs are decoded combinationally from state, Opcode, Func and MemReady. All outputs not listed for a state are 0.
- FETCH:
  - Asserts Fetch, MemReq, IorD=0, ALUSrc=0, ALUControl=0.
  - IRWrite=PCWrite=MemReady (Mealy). The FSM stays in FETCH until MemReady=1, then moves to DECODE.
- DECODE:
  - ALUControl=0, used for the branch-target add.
  - Next state: R-type → REXE; ADDI/ANDI/ORI/XORI/LUI → IEXE; LW/SW → ADDR; BEQ(000100)/BNE(000101) → BR; J(000010) → JMP; anything else → TRAP (TRAP_ILLEGAL=1) or FETCH.
- REXE:
  - ALUControl from Func: 100000→0, 100010→1, 100100→2, 100101→3, 100110→4, 000000→5, 000010→6.
  - Shift=1 for SLL/SRL. Moves to RWB.
- RWB: same ALUControl and Shift as REXE, plus RegDst=1, RegWrite=1, InstrDone=1. Moves to FETCH.
- IEXE:
  - ALUSrc=1. ALUControl: ADDI 0, ANDI 2, ORI 3, XORI 4, LUI 7.
  - Moves to IWB.
- IWB: IEXE signals plus RegWrite=1, RegDst=0, InstrDone=1. Moves to FETCH.
- ADDR: ALUSrc=1, ALUControl=0. LW → MRD, SW → MWR.
- MRD: MemReq=1, IorD=1. Waits for MemReady, then moves to MWB.
- MWB: MemToReg=1, RegWrite=1, InstrDone=1. Moves to FETCH.
- MWR:
  - MemReq=1, IorD=1, MemWrite=1.
  - Waits for MemReady. InstrDone=MemReady (Mealy). Then moves to FETCH.
- BR:
  - ALUControl=1, PCWriteCond=1, PCSrc=1, BranchNE=(Opcode==000101), InstrDone=1.
  - Moves to FETCH. The datapath computes PCWrite|(PCWriteCond&(Zero^BranchNE)).
- JMP: PCWrite=1, PCSrc=2, InstrDone=1. Moves to FETCH.
- Timeout:
  - The counter clears on entry to FETCH/MRD/MWR and whenever MemReady=1. It increments each wait cycle.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT-1 with MemReady still 0, the next state is TRAP and MemFault is set.
  - The timeout has priority only when MemReady=0. MemReady=1 on the last allowed cycle completes normally.
- TRAP: all controls are 0, flags hold, and the FSM stays until reset. Reset in any state, including mid-wait, returns to RST with no write enables asserted.
- Instruction cycles with MemReady tied to 1: R/I-type 4, LW 5, SW 4, BEQ/BNE 3, J 3. Each memory wait cycle adds 1.

Test Plan:
- Reset, then MemReady=1 and ADD (Opcode 0, Func 100000) → states FETCH, DECODE, REXE, RWB. In cycle 4, RegWrite=1, RegDst=1, ALUControl=0, InstrDone=1.
- LW with MemReady low for 3 cycles in MRD → MemReq held 3 cycles, then MWB with MemToReg=1, RegWrite=1. Total 8 cycles.
- BNE (000101) → BR with PCWriteCond=1, BranchNE=1, ALUControl=1, PCSrc=1. Next state FETCH after 3 cycles total.
- MEM_TIMEOUT=4, MemReady stuck 0 in FETCH → TRAP after 4 wait cycles. MemFault=1, IRWrite never 1, and the FSM stays in TRAP until reset.
- Opcode 111111 with TRAP_ILLEGAL=1 → Illegal=1 after DECODE. With TRAP_ILLEGAL=0 → back to FETCH, Illegal=0.
- Assert reset asynchronously mid-MWR → MemWrite and MemReq drop immediately (before the next edge), state=RST, all outputs 0.
